// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus responder
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RAM      = 2'd0,
    IO       = 2'd1,
    VEC      = 2'd2,
    UNMAPPED = 2'd3
  } region_t;

  localparam logic [1:0]  GPIO_OUT      = 2'd0;
  localparam logic [1:0]  GPIO_IN       = 2'd1;
  localparam logic [1:0]  SCRATCH       = 2'd2;
  localparam logic [1:0]  STATUS        = 2'd3;
  localparam logic [15:0] VEC_LO_ADDR   = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR   = 16'hFFFD;
  localparam logic [7:0]  UNMAPPED_READ = 8'hFF;

endpackage

// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - single-port synchronous RAM with registered read port
module bus_ram #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - memory-mapped bus target: RAM, 4-register IO block, reset vector
module bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_AW       = 11,
  parameter int          RAM_WAIT     = 0,
  parameter logic [15:0] IO_BASE      = 16'hD000,
  parameter int          IO_WAIT      = 1,
  parameter logic [15:0] RESET_VECTOR = 16'h0200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_we,
  input  logic        i_req,
  output logic [7:0]  o_data,
  output logic        o_rdy,
  output logic        o_err,
  input  logic [7:0]  i_gpio,
  output logic [7:0]  o_gpio
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        we_q;
  region_t     region_q;

  region_t     dec_region;
  logic [3:0]  dec_wait;
  logic        accept, enter_resp;

  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic        cur_we;
  region_t     cur_region;

  logic [7:0]  gpio_meta, gpio_sync, scratch_q;
  logic        err_q;
  logic [7:0]  rd_data, resp_data_q, ram_rdata;
  logic        ram_rd_q, ram_we, ram_re, io_we;

  always_comb begin
    dec_region = UNMAPPED;
    dec_wait   = 4'd0;
    if (i_addr == VEC_LO_ADDR || i_addr == VEC_HI_ADDR) begin
      dec_region = VEC;
    end else if (i_addr[15:2] == IO_BASE[15:2]) begin
      dec_region = IO;
      dec_wait   = 4'(IO_WAIT);
    end else if ({16'd0, i_addr} < (32'd1 << RAM_AW)) begin
      dec_region = RAM;
      dec_wait   = 4'(RAM_WAIT);
    end
  end

  // Zero-wait accesses commit on the accept edge itself, so use the live bus then.
  always_comb begin
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    cur_we     = we_q;
    cur_region = region_q;
    if (state_q == IDLE) begin
      cur_addr   = i_addr;
      cur_wdata  = i_data;
      cur_we     = i_we;
      cur_region = dec_region;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (i_req) begin
        accept = 1'b1;
        cnt_d  = dec_wait;
        if (dec_wait == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 8'd0;
      we_q     <= 1'b0;
      region_q <= RAM;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q   <= i_addr;
        wdata_q  <= i_data;
        we_q     <= i_we;
        region_q <= dec_region;
      end
    end
  end

  // RAM has no reset, so its write strobe must not leak through while reset is held.
  assign ram_we = enter_resp && cur_we && cur_region == RAM && !i_rst;
  assign ram_re = enter_resp && !cur_we && cur_region == RAM;
  assign io_we  = enter_resp && cur_we && cur_region == IO;

  bus_ram #(.AW(RAM_AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_re    (ram_re),
    .i_addr  (cur_addr[RAM_AW-1:0]),
    .i_wdata (cur_wdata),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    rd_data = 8'h00;
    case (cur_region)
      VEC:      rd_data = (cur_addr == VEC_HI_ADDR) ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
      UNMAPPED: rd_data = UNMAPPED_READ;
      IO: begin
        case (cur_addr[1:0])
          GPIO_OUT: rd_data = o_gpio;
          GPIO_IN:  rd_data = gpio_sync;
          SCRATCH:  rd_data = scratch_q;
          STATUS:   rd_data = {7'd0, err_q};
          default:  rd_data = 8'h00;
        endcase
      end
      default:  rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gpio_meta <= 8'd0;
      gpio_sync <= 8'd0;
      o_gpio    <= 8'd0;
      scratch_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      gpio_meta <= i_gpio;
      gpio_sync <= gpio_meta;
      if (io_we && cur_addr[1:0] == GPIO_OUT) o_gpio <= cur_wdata;
      if (io_we && cur_addr[1:0] == SCRATCH) scratch_q <= cur_wdata;
      if (enter_resp && cur_region == UNMAPPED) begin
        err_q <= 1'b1;
      end else if (io_we && cur_addr[1:0] == STATUS && cur_wdata[0]) begin
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdy       <= 1'b0;
      o_err       <= 1'b0;
      resp_data_q <= 8'd0;
      ram_rd_q    <= 1'b0;
    end else if (enter_resp) begin
      o_rdy       <= 1'b1;
      o_err       <= (cur_region == UNMAPPED);
      resp_data_q <= cur_we ? 8'h00 : rd_data;
      ram_rd_q    <= ram_re;
    end else if (state_q == RESP) begin
      o_rdy       <= 1'b0;
      o_err       <= 1'b0;
      resp_data_q <= 8'd0;
      ram_rd_q    <= 1'b0;
    end
  end

  assign o_data = ram_rd_q ? ram_rdata : resp_data_q;

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - table-driven scoreboard bench for bus_responder
module tb_bus_responder;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [7:0]  exp_gpio;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst1 = 1'b1, rst3 = 1'b1;
  logic [15:0] addr = 16'd0;
  logic [7:0]  wdata = 8'd0, gpio_in = 8'h81;
  logic        we = 1'b0, req = 1'b0, sel = 1'b0;
  logic [7:0]  data1, data3, gpio1, gpio3;
  logic        rdy1, rdy3, err1, err3;
  logic [7:0]  m_data, m_gpio;
  logic        m_rdy, m_err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[22];

  always #5 clk = ~clk;

  bus_responder dut (
    .i_clk(clk), .i_rst(rst1), .i_addr(addr), .i_data(wdata), .i_we(we),
    .i_req(req && !sel), .o_data(data1), .o_rdy(rdy1), .o_err(err1),
    .i_gpio(gpio_in), .o_gpio(gpio1)
  );

  bus_responder #(.IO_WAIT(3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_addr(addr), .i_data(wdata), .i_we(we),
    .i_req(req && sel), .o_data(data3), .o_rdy(rdy3), .o_err(err3),
    .i_gpio(gpio_in), .o_gpio(gpio3)
  );

  assign m_data = sel ? data3 : data1;
  assign m_rdy  = sel ? rdy3 : rdy1;
  assign m_err  = sel ? err3 : err1;
  assign m_gpio = sel ? gpio3 : gpio1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input string name, input logic [15:0] a, input logic [7:0] d,
                         input logic w, input logic [7:0] ed, input logic ee,
                         input int el, input logic [7:0] eg);
    exp_t e, got_e;
    int   lat;
    bit   got;
    e.data = ed; e.err = ee; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    addr = a; wdata = d; we = w; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (m_rdy) got = 1;
    end
    got_e = sb.pop_front();
    if (!got) begin
      chk({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, " data"}, {24'd0, m_data}, {24'd0, got_e.data});
      chk({name, " err"}, {31'd0, m_err}, {31'd0, got_e.err});
      chk({name, " lat"}, lat, got_e.lat);
      chk({name, " gpio"}, {24'd0, m_gpio}, {24'd0, eg});
      @(negedge clk);
      chk({name, " pulse"}, {31'd0, m_rdy}, 32'd0);
    end
  endtask

  initial begin
    int pulses;
    tbl[0]  = '{16'h0123, 8'h5A, 1'b1, 8'h00, 1'b0, 1, 8'h00};
    tbl[1]  = '{16'h0123, 8'h00, 1'b0, 8'h5A, 1'b0, 1, 8'h00};
    tbl[2]  = '{16'hD000, 8'hC3, 1'b1, 8'h00, 1'b0, 2, 8'hC3};
    tbl[3]  = '{16'hD000, 8'h00, 1'b0, 8'hC3, 1'b0, 2, 8'hC3};
    tbl[4]  = '{16'hD001, 8'h00, 1'b0, 8'h81, 1'b0, 2, 8'hC3};
    tbl[5]  = '{16'hD001, 8'hFF, 1'b1, 8'h00, 1'b0, 2, 8'hC3};
    tbl[6]  = '{16'hD001, 8'h00, 1'b0, 8'h81, 1'b0, 2, 8'hC3};
    tbl[7]  = '{16'hFFFC, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'hC3};
    tbl[8]  = '{16'hFFFD, 8'h00, 1'b0, 8'h02, 1'b0, 1, 8'hC3};
    tbl[9]  = '{16'hFFFC, 8'h55, 1'b1, 8'h00, 1'b0, 1, 8'hC3};
    tbl[10] = '{16'hFFFC, 8'h00, 1'b0, 8'h00, 1'b0, 1, 8'hC3};
    tbl[11] = '{16'hD003, 8'h00, 1'b0, 8'h00, 1'b0, 2, 8'hC3};
    tbl[12] = '{16'h8000, 8'h00, 1'b0, 8'hFF, 1'b1, 1, 8'hC3};
    tbl[13] = '{16'hD003, 8'h00, 1'b0, 8'h01, 1'b0, 2, 8'hC3};
    tbl[14] = '{16'hD003, 8'h01, 1'b1, 8'h00, 1'b0, 2, 8'hC3};
    tbl[15] = '{16'hD003, 8'h00, 1'b0, 8'h00, 1'b0, 2, 8'hC3};
    tbl[16] = '{16'h07FF, 8'hA5, 1'b1, 8'h00, 1'b0, 1, 8'hC3};
    tbl[17] = '{16'h07FF, 8'h00, 1'b0, 8'hA5, 1'b0, 1, 8'hC3};
    tbl[18] = '{16'h0800, 8'h00, 1'b0, 8'hFF, 1'b1, 1, 8'hC3};
    tbl[19] = '{16'hD004, 8'h12, 1'b1, 8'h00, 1'b1, 1, 8'hC3};
    tbl[20] = '{16'hD002, 8'h3C, 1'b1, 8'h00, 1'b0, 2, 8'hC3};
    tbl[21] = '{16'hD002, 8'h00, 1'b0, 8'h3C, 1'b0, 2, 8'hC3};

    repeat (3) @(negedge clk);
    chk("reset o_data", {24'd0, data1}, 32'd0);
    chk("reset o_rdy", {31'd0, rdy1}, 32'd0);
    chk("reset o_err", {31'd0, err1}, 32'd0);
    chk("reset o_gpio", {24'd0, gpio1}, 32'd0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].we,
              tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_gpio);
    end

    // IO_WAIT=3 instance: full-latency write/read, then reset during WAIT
    sel = 1'b1;
    run_txn("w3 write", 16'hD002, 8'h77, 1'b1, 8'h00, 1'b0, 4, 8'h00);
    run_txn("w3 read", 16'hD002, 8'h00, 1'b0, 8'h77, 1'b0, 4, 8'h00);
    run_txn("w3 clr", 16'hD002, 8'h00, 1'b1, 8'h00, 1'b0, 4, 8'h00);
    @(negedge clk);
    addr = 16'hD002; wdata = 8'h77; we = 1'b1; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rdy3) pulses++;
      if (c == 2) rst3 = 1'b0;
    end
    chk("abort no rdy", pulses, 0);
    run_txn("abort read", 16'hD002, 8'h00, 1'b0, 8'h00, 1'b0, 4, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
